// File: rtl/ts_merge_arbiter.sv
// N-input AXI4-Stream packet merge: forwards whole packets in ascending (wrap-safe) timestamp
// order, round-robin on ties, with per-input fall-through FIFOs and an output packet counter.
module ts_merge_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_NUM_INPUT_IF     = 5,
  parameter int unsigned C_FIFO_DEPTH_BITS    = 2,
  parameter int unsigned C_TS_LSB             = 32,
  parameter int unsigned C_TS_WIDTH           = 32
) (
  input  logic                                                 axi_aclk,
  input  logic                                                 axi_areset,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                     m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                      m_axis_tuser,
  output logic                                                 m_axis_tvalid,
  input  logic                                                 m_axis_tready,
  output logic                                                 m_axis_tlast,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                          s_axis_tvalid_grp,
  output logic [C_S_NUM_INPUT_IF-1:0]                          s_axis_tready_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                          s_axis_tlast_grp,
  input  logic                                                 sw_rst,
  output logic [31:0]                                          m_pkt_count
);

  localparam int unsigned N  = C_S_NUM_INPUT_IF;
  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned AW = C_FIFO_DEPTH_BITS;
  localparam int unsigned D  = 2 ** C_FIFO_DEPTH_BITS;
  localparam int unsigned W  = C_TS_WIDTH;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned EW = DW + SW + UW + 1;

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  // FIFO entry layout: {data, strb, user, last}
  logic [EW-1:0]          mem [N][D];
  logic [N-1:0][AW-1:0]   wr_ptr, rd_ptr;
  logic [N-1:0][AW:0]     count;
  logic [N-1:0]           empty, wr_en, rd_en;
  logic [N-1:0][EW-1:0]   head;
  logic [N-1:0][W-1:0]    ts;

  state_t                 state, state_nxt;
  logic [IW-1:0]          grant, grant_nxt;
  logic [IW-1:0]          rr_ptr, rr_nxt;
  logic [IW-1:0]          best;
  logic                   found;
  logic                   pkt_done;
  logic [EW-1:0]          sel;

  // a earlier than b when (a-b) mod 2**W is negative
  function automatic logic ts_earlier(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] diff;
    diff = a - b;
    return diff[W-1];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      empty[i]             = (count[i] == '0);
      s_axis_tready_grp[i] = (count[i] < (AW+1)'(D - 1)) && !axi_areset && !sw_rst;
      wr_en[i]             = s_axis_tvalid_grp[i] && s_axis_tready_grp[i];
      head[i]              = mem[i][rd_ptr[i]];
      ts[i]                = head[i][1 + C_TS_LSB +: W];
    end
  end

  // FIFO storage needs no reset; occupancy tracking does
  always_ff @(posedge axi_aclk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= {s_axis_tdata_grp[i*DW +: DW], s_axis_tstrb_grp[i*SW +: SW],
                              s_axis_tuser_grp[i*UW +: UW], s_axis_tlast_grp[i]};
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({wr_en[i], rd_en[i]})
          2'b10:   count[i] <= count[i] + (AW+1)'(1);
          2'b01:   count[i] <= count[i] - (AW+1)'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Scan in round-robin order from rr_ptr; only a strictly earlier head displaces the pick
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    best  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr_ptr) + k) % N;
      if (!empty[idx] && (!found || ts_earlier(ts[idx], ts[best]))) begin
        best  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      m_pkt_count <= '0;
    end else if (sw_rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      m_pkt_count <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
      if (pkt_done) m_pkt_count <= m_pkt_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_nxt        = rr_ptr;
    rd_en         = '0;
    pkt_done      = 1'b0;
    sel           = head[grant];
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          grant_nxt = best;
          rr_nxt    = IW'((32'(best) + 32'd1) % N);
          state_nxt = ST_PKT;
        end
      end
      ST_PKT: begin
        m_axis_tdata  = sel[EW-1 -: DW];
        m_axis_tstrb  = sel[UW + SW : UW + 1];
        m_axis_tuser  = sel[UW:1];
        m_axis_tlast  = sel[0];
        m_axis_tvalid = !empty[grant];
        // Stay locked on grant even while its FIFO runs dry mid-packet
        if (m_axis_tvalid && m_axis_tready) begin
          rd_en[grant] = 1'b1;
          if (sel[0]) begin
            pkt_done  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ts_merge_arbiter.sv
// Randomised packet traffic on 5 ports, checked cycle by cycle against a queue-based
// model of packet ordering, backpressure and packet counting.
module tb_ts_merge_arbiter;

  localparam int N = 5;
  localparam int D = 4;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           axi_areset;
  logic           sw_rst;
  logic [255:0]   m_axis_tdata;
  logic [31:0]    m_axis_tstrb;
  logic [127:0]   m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [N*256-1:0] s_axis_tdata_grp;
  logic [N*32-1:0]  s_axis_tstrb_grp;
  logic [N*128-1:0] s_axis_tuser_grp;
  logic [N-1:0]   s_axis_tvalid_grp;
  logic [N-1:0]   s_axis_tready_grp;
  logic [N-1:0]   s_axis_tlast_grp;
  logic [31:0]    m_pkt_count;

  ts_merge_arbiter dut (
    .axi_aclk          (clk),
    .axi_areset        (axi_areset),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tstrb      (m_axis_tstrb),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .s_axis_tdata_grp  (s_axis_tdata_grp),
    .s_axis_tstrb_grp  (s_axis_tstrb_grp),
    .s_axis_tuser_grp  (s_axis_tuser_grp),
    .s_axis_tvalid_grp (s_axis_tvalid_grp),
    .s_axis_tready_grp (s_axis_tready_grp),
    .s_axis_tlast_grp  (s_axis_tlast_grp),
    .sw_rst            (sw_rst),
    .m_pkt_count       (m_pkt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Source drivers: current offered beat and beats left in the packet
  beat_t cur [N];
  int    rem [N];
  logic  vld [N];
  logic  acc [N];
  int    pkt_rate;
  int    cyc;

  // Reference: queue per port mirrors what the input has accepted but not yet sent
  beat_t mq [N][$];
  bit    busy;
  int    g;
  int    rr;
  int    exp_cnt;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_axis_tdata_grp[i*256 +: 256] = cur[i].data;
      s_axis_tstrb_grp[i*32 +: 32]   = cur[i].strb;
      s_axis_tuser_grp[i*128 +: 128] = cur[i].user;
      s_axis_tlast_grp[i]            = cur[i].last;
      s_axis_tvalid_grp[i]           = vld[i];
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit earlier(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return d[31];
  endfunction

  function automatic logic [31:0] head_ts(input int p);
    return mq[p][0].user[63:32];
  endfunction

  // Earliest non-empty port; among equal-earliest the first in round-robin order from rr
  function automatic int pick();
    int p;
    bit is_min;
    p = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (mq[idx].size() != 0 && p < 0) begin
        is_min = 1'b1;
        for (int j = 0; j < N; j++)
          if (j != idx && mq[j].size() != 0 && earlier(head_ts(j), head_ts(idx))) is_min = 1'b0;
        if (is_min) p = idx;
      end
    end
    return p;
  endfunction

  function automatic beat_t rand_beat(input bit first, input bit last);
    beat_t b;
    for (int j = 0; j < 8; j++) b.data[j*32 +: 32] = $urandom;
    b.strb = $urandom;
    for (int j = 0; j < 4; j++) b.user[j*32 +: 32] = $urandom;
    if (first) b.user[63:32] = 32'hFFFF_FFF8 + 32'($urandom_range(0, 15));
    b.last = last;
    return b;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      rem[i] = 0;
      vld[i] = 1'b0;
      acc[i] = 1'b0;
    end
    busy    = 1'b0;
    g       = 0;
    rr      = 0;
    exp_cnt = 0;
  endtask

  // Called mid-cycle: compare DUT against model, then advance model to the next edge
  task automatic model_step();
    logic [N-1:0] exp_rdy;
    bit fire;
    int p;
    if (axi_areset || sw_rst) begin
      check("tready_in_reset", 256'(s_axis_tready_grp), 256'(0));
      clear_all();
      return;
    end
    for (int i = 0; i < N; i++) begin
      exp_rdy[i] = (mq[i].size() < D - 1);
      acc[i]     = vld[i] && s_axis_tready_grp[i];
    end
    check("s_tready", 256'(s_axis_tready_grp), 256'(exp_rdy));
    check("pkt_count", 256'(m_pkt_count), 256'(exp_cnt));
    fire = 1'b0;
    if (!busy) begin
      check("idle_tvalid", 256'(m_axis_tvalid), 256'(0));
      check("idle_tdata", m_axis_tdata, 256'(0));
      p = pick();
      if (p >= 0) begin
        busy = 1'b1;
        g    = p;
        rr   = (p + 1) % N;
      end
    end else begin
      check("tvalid", 256'(m_axis_tvalid), 256'(mq[g].size() != 0));
      if (mq[g].size() != 0) begin
        check("tdata", m_axis_tdata, mq[g][0].data);
        check("tstrb", 256'(m_axis_tstrb), 256'(mq[g][0].strb));
        check("tuser", 256'(m_axis_tuser), 256'(mq[g][0].user));
        check("tlast", 256'(m_axis_tlast), 256'(mq[g][0].last));
        fire = m_axis_tready;
      end
    end
    if (fire) begin
      beat_t b;
      b = mq[g].pop_front();
      if (b.last) begin
        exp_cnt++;
        busy = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(cur[i]);
  endtask

  // Called just after a rising edge: new source and sink stimulus
  task automatic drive();
    sw_rst = (cyc == 900 || cyc == 1700);
    if (cyc >= 400 && cyc < 430) m_axis_tready = 1'b0;
    else if (cyc >= 1000 && cyc < 1150) m_axis_tready = 1'b1;
    else m_axis_tready = ($urandom_range(0, 99) < 70);
    for (int i = 0; i < N; i++) begin
      if (vld[i] && acc[i]) begin
        rem[i]--;
        vld[i] = 1'b0;
        if (rem[i] > 0) cur[i] = rand_beat(1'b0, rem[i] == 1);
      end
      if (!vld[i]) begin
        if (rem[i] == 0 && $urandom_range(0, 99) < pkt_rate) begin
          rem[i] = $urandom_range(1, 4);
          cur[i] = rand_beat(1'b1, rem[i] == 1);
        end
        if (rem[i] > 0 && $urandom_range(0, 99) < 80) vld[i] = 1'b1;
      end
    end
  endtask

  initial begin
    bit done;
    axi_areset    = 1'b1;
    sw_rst        = 1'b0;
    m_axis_tready = 1'b0;
    pkt_rate      = 30;
    cyc           = 0;
    for (int i = 0; i < N; i++) cur[i] = '0;
    clear_all();
    #2;
    check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_tlast", 256'(m_axis_tlast), 256'(0));
    check("rst_tdata", m_axis_tdata, 256'(0));
    check("rst_pkt_count", 256'(m_pkt_count), 256'(0));
    check("rst_tready", 256'(s_axis_tready_grp), 256'(0));
    repeat (3) @(posedge clk);
    #1 axi_areset = 1'b0;

    for (cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      if (axi_areset) axi_areset = 1'b0;
      drive();
      if (cyc == 1200) begin
        #2 axi_areset = 1'b1;
        #1;
        check("arst_tvalid", 256'(m_axis_tvalid), 256'(0));
        check("arst_pkt_count", 256'(m_pkt_count), 256'(0));
        check("arst_tready", 256'(s_axis_tready_grp), 256'(0));
      end
    end

    // Drain: no new packets, sink always ready, bounded wait for everything to come out
    pkt_rate = 0;
    done     = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      model_step();
      done = !busy;
      for (int i = 0; i < N; i++) if (rem[i] != 0 || mq[i].size() != 0) done = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      drive();
      m_axis_tready = 1'b1;
    end
    check("drain_done", 256'(done), 256'(1));
    @(negedge clk);
    check("final_pkt_count", 256'(m_pkt_count), 256'(exp_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
